// File: rtl/fetch_unit_pkg.sv
// Package shared by the fetch unit and its prefetch queue.
// It exposes the fetch constants as typed localparams and provides a
// parameter-legality helper.
`include "parameters.vh"

package fetch_unit_pkg;

  localparam int INSTR_W    = `FETCH_INSTR_W;
  localparam int PC_STEP    = `FETCH_PC_STEP;
  localparam int ALIGN_BITS = `FETCH_ALIGN_BITS;

  // The queue depth must be a power of two between 2 and 16 so that the
  // pointers wrap for free.
  function automatic bit depth_is_legal(input int depth);
    return (depth >= 2) && (depth <= 16) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: a circular buffer of DEPTH entries, each WIDTH bits wide.
// It supports push, pop, flush and reports its occupancy.
// A flush or reset empties the queue and returns both pointers to zero.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             full;

  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two from 2 to 16");
  end

  // Derive the head view and the occupancy flags from the pointers and the count.
  always_comb begin
    o_empty = (count == '0);
    full    = (count == FULL_COUNT);
    do_pop  = i_pop && !o_empty;
    o_head  = mem[rd_ptr];
    o_count = count;
  end

  // Maintain the pointers and the count; flush has the same effect as reset.
  always_ff @(posedge clk) begin
    if (i_reset || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({i_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Store the payload at the tail; storage needs no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (i_push) begin
      mem[wr_ptr] <= i_push_data;
    end
  end

  // The fetch controller reserves a slot before requesting, so a push into a full queue is a bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (i_reset || i_flush)
                                  !(i_push && full));

endmodule

// File: rtl/parameters.vh
// Shared fetch-path constants: instruction width, fetch step and PC alignment.
`ifndef FETCH_PARAMETERS_VH
`define FETCH_PARAMETERS_VH

`define FETCH_INSTR_W    32
`define FETCH_PC_STEP    4
`define FETCH_ALIGN_BITS 2

`endif

// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// It keeps a fetch PC and issues one ROM read per cycle whenever a queue slot
// can be reserved. Each ROM response is pushed, together with its PC, into a
// prefetch queue that the decoder drains through a valid/ready handshake.
// A redirect flushes the queue, drops any response still in flight and
// restarts fetching at the word-aligned target on the following cycle.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    i_reset,
  output logic [XLEN-1:0]         o_rom_pc,
  output logic                    o_rom_req,
  input  logic [31:0]             i_rom_instr,
  input  logic                    i_redirect,
  input  logic [XLEN-1:0]         i_redirect_pc,
  output logic                    o_instr_valid,
  output logic [31:0]             o_instr,
  output logic [XLEN-1:0]         o_instr_pc,
  input  logic                    i_instr_ready,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + XLEN;
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]    fetch_pc;
  logic [XLEN-1:0]    req_pc;
  logic               inflight;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     occupancy;
  logic [XLEN-1:0]    redirect_target;
  logic               push;
  logic               pop;
  logic               q_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               unused_redirect_bits;

  if (RESET_PC[ALIGN_BITS-1:0] != '0) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word aligned");
  end

  // Decide whether to request this cycle; an in-flight response already owns a queue slot.
  always_comb begin
    occupancy       = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    o_rom_req       = !i_reset && !i_redirect && (occupancy < DEPTH_EXT);
    o_rom_pc        = fetch_pc;
    redirect_target = {i_redirect_pc[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    unused_redirect_bits = &{1'b0, i_redirect_pc[ALIGN_BITS-1:0]};
  end

  // Route responses into the queue and present its head to the consumer.
  always_comb begin
    push          = inflight && !i_redirect && !i_reset;
    push_entry    = {i_rom_instr, req_pc};
    o_instr_valid = !q_empty;
    pop           = o_instr_valid && i_instr_ready;
    o_instr       = head_entry[ENTRY_W-1 -: INSTR_W];
    o_instr_pc    = head_entry[XLEN-1:0];
    o_count       = count;
  end

  // Advance the fetch PC per request, remember which PC is in flight, and restart on redirect.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (i_redirect) begin
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
    end else begin
      inflight <= o_rom_req;
      if (o_rom_req) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_flush     (i_redirect),
    .i_push      (push),
    .i_push_data (push_entry),
    .i_pop       (pop),
    .o_head      (head_entry),
    .o_count     (count),
    .o_empty     (q_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit.
// A queue-based reference model is compared against the DUT on every cycle.
// Hand-computed literal checks cover reset release, backpressure, redirect,
// redirect with a handshake, PC wrap-around and reset in mid-stream.
module tb_fetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC0 = 32'h0000_0000;
  localparam logic [31:0] RESET_PC1 = 32'hFFFF_FFF8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset       = 1'b1;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready       = 1'b0;

  logic [31:0]      rom_pc0, rom_instr0, instr0, instr_pc0;
  logic             rom_req0, instr_valid0;
  logic [CNT_W-1:0] count0;

  logic [31:0]      rom_pc1, rom_instr1, instr1, instr_pc1;
  logic             rom_req1, instr_valid1;
  logic [CNT_W-1:0] count1;
  logic             redirect1    = 1'b0;
  logic [31:0]      redirect_pc1 = '0;
  logic             ready1       = 1'b0;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC0)) dut0 (
    .clk(clk), .i_reset(reset), .o_rom_pc(rom_pc0), .o_rom_req(rom_req0),
    .i_rom_instr(rom_instr0), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_instr_valid(instr_valid0), .o_instr(instr0), .o_instr_pc(instr_pc0),
    .i_instr_ready(ready), .o_count(count0)
  );

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC1)) dut1 (
    .clk(clk), .i_reset(reset), .o_rom_pc(rom_pc1), .o_rom_req(rom_req1),
    .i_rom_instr(rom_instr1), .i_redirect(redirect1), .i_redirect_pc(redirect_pc1),
    .o_instr_valid(instr_valid1), .o_instr(instr1), .o_instr_pc(instr_pc1),
    .i_instr_ready(ready1), .o_count(count1)
  );

  // ROM: word k holds k; it answers one cycle after a request and returns garbage otherwise.
  always @(posedge clk) begin
    rom_instr0 <= rom_req0 ? {2'b00, rom_pc0[31:2]} : 32'hDEAD_BEEF;
    rom_instr1 <= rom_req1 ? {2'b00, rom_pc1[31:2]} : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs shortly after the rising edge and let them settle.
  task automatic applyStimulus(input logic rst, input logic redir,
                               input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #2;
    reset       = rst;
    redirect    = redir;
    redirect_pc = rpc;
    ready       = rdy;
    #1;
  endtask

  // Reference model for dut0: fetch address, one pending response and a FIFO of queued PCs.
  logic [31:0] m_q[$];
  logic [31:0] m_pc       = RESET_PC0;
  bit          m_infl     = 1'b0;
  logic [31:0] m_infl_pc  = '0;

  function automatic bit exp_req();
    return !reset && !redirect && ((m_q.size() + int'(m_infl)) < DEPTH);
  endfunction

  always @(posedge clk) begin
    bit r;
    if (reset) begin
      m_q.delete();
      m_pc   = RESET_PC0;
      m_infl = 1'b0;
    end else begin
      r = exp_req();
      if (m_q.size() != 0 && ready) void'(m_q.pop_front());
      if (redirect) begin
        m_q.delete();
        m_infl = 1'b0;
        m_pc   = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl    = r;
        m_infl_pc = m_pc;
        if (r) m_pc = m_pc + 32'd4;
      end
    end
  end

  // Compare dut0 against the model mid-cycle; head fields only matter when valid.
  always @(negedge clk) begin
    checkOutput("model rom_req", 64'(rom_req0), 64'(exp_req()));
    checkOutput("model rom_pc", 64'(rom_pc0), 64'(m_pc));
    checkOutput("model count", 64'(count0), 64'(m_q.size()));
    checkOutput("model valid", 64'(instr_valid0), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      checkOutput("model instr_pc", 64'(instr_pc0), 64'(m_q[0]));
      checkOutput("model instr", 64'(instr0), 64'(m_q[0] >> 2));
    end
  end

  initial begin
    // Reset held for three cycles.
    repeat (3) applyStimulus(1, 0, 0, 0);
    checkOutput("rst rom_req", 64'(rom_req0), 64'd0);
    checkOutput("rst valid", 64'(instr_valid0), 64'd0);
    checkOutput("rst count", 64'(count0), 64'd0);
    checkOutput("rst rom_pc", 64'(rom_pc0), 64'h0);
    checkOutput("rst rom_pc wrap", 64'(rom_pc1), 64'hFFFF_FFF8);

    // Release with ready low: 0,4,8,12 then stop at four in flight/queued.
    applyStimulus(0, 0, 0, 0);
    checkOutput("R0 rom_pc", 64'(rom_pc0), 64'h0);
    checkOutput("R0 rom_req", 64'(rom_req0), 64'd1);
    checkOutput("R0 valid", 64'(instr_valid0), 64'd0);
    checkOutput("R0 wrap pc", 64'(rom_pc1), 64'hFFFF_FFF8);
    checkOutput("R0 wrap req", 64'(rom_req1), 64'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("R1 rom_pc", 64'(rom_pc0), 64'h4);
    checkOutput("R1 valid", 64'(instr_valid0), 64'd0);
    checkOutput("R1 wrap pc", 64'(rom_pc1), 64'hFFFF_FFFC);
    checkOutput("R1 wrap req", 64'(rom_req1), 64'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("R2 rom_pc", 64'(rom_pc0), 64'h8);
    checkOutput("R2 valid", 64'(instr_valid0), 64'd1);
    checkOutput("R2 instr", 64'(instr0), 64'h0);
    checkOutput("R2 instr_pc", 64'(instr_pc0), 64'h0);
    checkOutput("R2 wrap pc", 64'(rom_pc1), 64'h0);
    checkOutput("R2 wrap req", 64'(rom_req1), 64'd1);
    checkOutput("R2 wrap instr_pc", 64'(instr_pc1), 64'hFFFF_FFF8);
    checkOutput("R2 wrap instr", 64'(instr1), 64'h3FFF_FFFE);
    applyStimulus(0, 0, 0, 0);
    checkOutput("R3 rom_pc", 64'(rom_pc0), 64'hC);
    checkOutput("R3 rom_req", 64'(rom_req0), 64'd1);
    checkOutput("R3 count", 64'(count0), 64'd2);
    checkOutput("R3 wrap pc", 64'(rom_pc1), 64'h4);
    checkOutput("R3 wrap req", 64'(rom_req1), 64'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("R4 rom_req", 64'(rom_req0), 64'd0);
    checkOutput("R4 count", 64'(count0), 64'd3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("R5 count", 64'(count0), 64'd4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("R6 count", 64'(count0), 64'd4);
    checkOutput("R6 rom_req", 64'(rom_req0), 64'd0);

    // A single pop releases exactly one request.
    applyStimulus(0, 0, 0, 1);
    checkOutput("pop head pc", 64'(instr_pc0), 64'h0);
    checkOutput("pop rom_req", 64'(rom_req0), 64'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("after pop count", 64'(count0), 64'd3);
    checkOutput("after pop rom_req", 64'(rom_req0), 64'd1);
    checkOutput("after pop rom_pc", 64'(rom_pc0), 64'h10);
    checkOutput("after pop head", 64'(instr_pc0), 64'h4);
    applyStimulus(0, 0, 0, 0);
    checkOutput("one req only", 64'(rom_req0), 64'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("refull count", 64'(count0), 64'd4);

    // Get three queued plus one in flight, then redirect to 0x103.
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("pre-redir rom_req", 64'(rom_req0), 64'd1);
    checkOutput("pre-redir count", 64'(count0), 64'd3);
    applyStimulus(0, 1, 32'h103, 0);
    checkOutput("redir cycle req", 64'(rom_req0), 64'd0);
    checkOutput("redir cycle head", 64'(instr_pc0), 64'h8);
    applyStimulus(0, 0, 0, 0);
    checkOutput("flush count", 64'(count0), 64'd0);
    checkOutput("flush valid", 64'(instr_valid0), 64'd0);
    checkOutput("target pc", 64'(rom_pc0), 64'h100);
    checkOutput("target req", 64'(rom_req0), 64'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("target+4 pc", 64'(rom_pc0), 64'h104);
    checkOutput("stale dropped", 64'(instr_valid0), 64'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("target head pc", 64'(instr_pc0), 64'h100);
    checkOutput("target head instr", 64'(instr0), 64'h40);
    checkOutput("target count", 64'(count0), 64'd1);

    // Redirect to 0, stream, and redirect to 0x200 while handing over PC 0x8.
    applyStimulus(0, 1, 32'h0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stream head 0", 64'(instr_pc0), 64'h0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("stream head 4", 64'(instr_pc0), 64'h4);
    applyStimulus(0, 1, 32'h200, 1);
    checkOutput("hs+redir valid", 64'(instr_valid0), 64'd1);
    checkOutput("hs+redir pc", 64'(instr_pc0), 64'h8);
    checkOutput("hs+redir instr", 64'(instr0), 64'h2);
    applyStimulus(0, 0, 0, 1);
    checkOutput("post hs valid", 64'(instr_valid0), 64'd0);
    checkOutput("post hs rom_pc", 64'(rom_pc0), 64'h200);
    applyStimulus(0, 0, 0, 1);
    checkOutput("post hs valid2", 64'(instr_valid0), 64'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("first target pc", 64'(instr_pc0), 64'h200);
    checkOutput("first target instr", 64'(instr0), 64'h80);
    applyStimulus(0, 0, 0, 1);
    checkOutput("sustain 204", 64'(instr_pc0), 64'h204);
    applyStimulus(0, 0, 0, 1);
    checkOutput("sustain 208", 64'(instr_pc0), 64'h208);

    // Fill the queue, then reset in mid-stream.
    repeat (6) applyStimulus(0, 0, 0, 0);
    checkOutput("full count", 64'(count0), 64'd4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("mid rst req", 64'(rom_req0), 64'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("after rst valid", 64'(instr_valid0), 64'd0);
    checkOutput("after rst count", 64'(count0), 64'd0);
    checkOutput("after rst rom_pc", 64'(rom_pc0), 64'h0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("after rst no stale", 64'(instr_valid0), 64'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("after rst head pc", 64'(instr_pc0), 64'h0);
    checkOutput("after rst head instr", 64'(instr0), 64'h0);

    // Mixed traffic; the per-cycle model check does the judging.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0,
                    $urandom & 32'h0000_03FF, 1'($urandom_range(0, 1)));
    end
    applyStimulus(0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
